aes128_pipe_core: RTL
=====================

// Module: aes128_pipe_core
// PURPOSE
//  Parametrised, fully pipelined AES-128 encryption core with valid/ready flow control.
//  Successor to the single-register cipher datapath. It reuses the existing round primitives
//  (keySchedule, SubBytes, ShiftRows, MixColumns, addRoundKey).
//  Pipeline register depth is selectable, it back-pressures its source, and the key is loaded
//  through a handshake.
//  Sits between the block-mode controller (upstream) and the ciphertext sink (downstream).
// PARAMETERS
//  ROUNDS_PER_STAGE  1    AES rounds per pipeline stage; legal values 1, 2, 5, 10 (others: $error at elaboration)
//  STAGES            10/ROUNDS_PER_STAGE (localparam)  number of stage registers = latency in cycles
//  CNT_W             32   width of the ciphertext block counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  key_in     in   128    cipher key, byte 0 in [127:120]
//  key_valid  in   1      key load request
//  key_ready  out  1      key may be loaded (pipeline empty)
//  in_data    in   128    plaintext block, byte 0 in [127:120]
//  in_valid   in   1      plaintext present
//  in_ready   out  1      core accepts plaintext this cycle
//  out_data   out  128    ciphertext block
//  out_valid  out  1      out_data valid
//  out_ready  in   1      sink accepts ciphertext
//  busy       out  1      any stage holds a valid block
//  blk_cnt    out  CNT_W  ciphertext blocks delivered since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync-released use): every stage valid bit=0, all stage data=0, key reg=0,
//   out_valid=0, out_data=0, blk_cnt=0, busy=0. Reset mid-operation drops all in-flight blocks silently.
//  Key path: 128-bit key register feeds combinational keySchedule (11 round keys).
//   key_ready = ~busy & ~in_valid_accept. Load occurs on the edge where key_valid & key_ready;
//   the key remains stable for all blocks in flight by construction.
//  Stages: s[1..STAGES], each {valid, 128-bit state}.
//   s[1] <= rounds 0..R of in_data (round 0 = initial addRoundKey, R = ROUNDS_PER_STAGE).
//   s[k] <= next R rounds applied to s[k-1]. Round 10 omits MixColumns. out_data = s[STAGES].state.
//  Flow: advance = ~s[STAGES].valid | out_ready. All stages shift together when advance=1, else all hold
//   (global stall; bubbles are not squeezed). in_ready = advance & ~key_valid_pending where key has
//   priority only if busy=0 (key_valid & ~busy -> in_ready=0 that cycle).
//   Accept = in_valid & in_ready; s[1].valid <= accept on each advance.
//  Latency: block accepted at edge n -> out_valid=1 with its ciphertext after edge n+STAGES-1, absent stalls.
//   Throughput is 1 block/cycle while out_ready=1.
//  out_valid/out_data hold stable while out_valid & ~out_ready (AXI-style; no retraction).
//  blk_cnt increments on each out_valid & out_ready edge; 2^CNT_W-1 -> 0.
//  Simultaneous: key_valid & in_valid while busy=0 -> key loads, plaintext waits a cycle.
//   Output handshake and input accept in the same cycle are both honoured.
//  busy = OR of stage valid bits (registered-state derived; no combinational path from inputs).
//  No combinational path from in_valid to out_valid; out_ready -> in_ready is combinational (documented).
// TESTING
//  T1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//     -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid after exactly STAGES edges from accept.
//  T2 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> 3925841d02dc09fbdc118597196a0b32. Run for ROUNDS_PER_STAGE = 1, 2, 5, 10.
//  T3 Streaming: 64 back-to-back blocks with out_ready=1 -> 64 correct blocks on consecutive cycles;
//     blk_cnt=64; in_ready never low.
//  T4 Back-pressure: out_ready random 30% duty -> no loss, duplication or reordering vs reference model;
//     out_data stable while stalled.
//  T5 Key change: key_valid asserted while busy -> key_ready=0 until drain.
//     Load then encrypt T1 pt -> old-key blocks use old key, new-key block correct.
//  T6 Reset mid-stream at STAGES/2 blocks in flight -> next cycle out_valid=0, busy=0, blk_cnt=0;
//     after release T1 repeats correctly once key reloaded (key reg=0).

Source files
------------

// File: rtl/aes128_pipe_core.sv
// Fully pipelined AES-128 encryption core, ROUNDS_PER_STAGE rounds per register stage.
// Valid/ready on both sides; the key loads through a handshake only while the pipeline is empty.
module aes128_pipe_core #(
    parameter int unsigned ROUNDS_PER_STAGE = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);
    localparam int unsigned R      = ROUNDS_PER_STAGE;
    localparam int unsigned STAGES = 10 / R;
    localparam int unsigned IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_rounds
        $error("aes128_pipe_core: ROUNDS_PER_STAGE must be 1, 2, 5 or 10");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [0:10][127:0] expand_key(input logic [127:0] k);
        logic [0:10][127:0] ks;
        logic [31:0]        w0, w1, w2, w3, tmp;
        logic [7:0]         rc;
        ks[0] = k;
        rc    = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = ks[4'(r - 1)];
            tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
            w0 ^= tmp;
            w1 ^= w0;
            w2 ^= w1;
            w3 ^= w2;
            ks[4'(r)] = {w0, w1, w2, w3};
            rc = xtime(rc);
        end
        return ks;
    endfunction

    // One cipher round; the final round skips MixColumns
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        int           src;
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) sb = {sb[119:0], sbox(8'(s >> (8 * (15 - i))))};
        for (int j = 0; j < 16; j++) begin
            src = (j % 4) + 4 * (((j / 4) + (j % 4)) % 4);
            sr  = {sr[119:0], 8'(sb >> (8 * (15 - src)))};
        end
        for (int c = 0; c < 4; c++) begin
            a0 = 8'(sr >> (8 * (15 - 4 * c)));
            a1 = 8'(sr >> (8 * (14 - 4 * c)));
            a2 = 8'(sr >> (8 * (13 - 4 * c)));
            a3 = 8'(sr >> (8 * (12 - 4 * c)));
            if (last) mc = {mc[95:0], a0, a1, a2, a3};
            else      mc = {mc[95:0],
                            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return mc ^ rk;
    endfunction

    function automatic logic [127:0] run_rounds(input logic [127:0] s, input int unsigned base,
                                                input logic [0:10][127:0] rks);
        logic [127:0] t;
        t = s;
        for (int unsigned r = 1; r <= R; r++) t = aes_round(t, rks[4'(base + r)], (base + r) == 10);
        return t;
    endfunction

    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES-1:0][127:0] st_q, st_d;
    logic [127:0]             key_q, key_d;
    logic [CNT_W-1:0]         blk_cnt_q, blk_cnt_d;
    logic [0:10][127:0]       rk;
    logic                     advance, accept, key_load;

    assign rk        = expand_key(key_q);
    assign busy      = |vld_q;
    assign out_valid = vld_q[STAGES-1];
    assign out_data  = st_q[IDX_W'(STAGES - 1)];
    assign blk_cnt   = blk_cnt_q;

    // Global stall; out_ready reaches in_ready combinationally. An idle key request wins over data.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance & ~(key_valid & ~busy);
    assign accept    = in_valid & in_ready;
    assign key_ready = ~busy & ~accept;
    assign key_load  = key_valid & key_ready;

    always_comb begin
        vld_d     = vld_q;
        st_d      = st_q;
        key_d     = key_q;
        blk_cnt_d = blk_cnt_q;
        if (advance) begin
            vld_d   = STAGES'({vld_q, accept});
            st_d[0] = run_rounds(in_data ^ rk[0], 0, rk);
            for (int unsigned k = 1; k < STAGES; k++) begin
                st_d[IDX_W'(k)] = run_rounds(st_q[IDX_W'(k - 1)], k * R, rk);
            end
        end
        if (key_load) key_d = key_in;
        if (out_valid && out_ready) blk_cnt_d = blk_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            st_q      <= '0;
            key_q     <= '0;
            blk_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            st_q      <= st_d;
            key_q     <= key_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end
endmodule
